// File: rtl/applyconvolution_mul_arbiter_pkg.sv
// Shared constants and the round-robin pick function for the multiplier
// arbiter slice.
//   N_REQ_MAX : largest supported requester count
//   DIN_W     : multiplier operand width
//   DOUT_W    : multiplier product width
//   MUL_LAT   : cycles from operand register to product register output
//   rr_pick   : scans a request vector starting one past ptr, wrapping at n
package applyConvolution_mul_pkg;

  localparam int N_REQ_MAX = 8;
  localparam int DIN_W     = 32;
  localparam int DOUT_W    = 64;
  localparam int MUL_LAT   = 2;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or after (ptr+1) mod n, wrapping.
  function automatic rr_pick_t rr_pick(input logic [N_REQ_MAX-1:0] req,
                                       input logic [2:0]           ptr,
                                       input int                   n);
    rr_pick_t r;
    int       cand;
    r = '0;
    for (int k = 1; k <= N_REQ_MAX; k++) begin
      if (k <= n && !r.found) begin
        cand = (int'(ptr) + k) % n;
        if (req[cand[2:0]]) begin
          r.found = 1'b1;
          r.idx   = cand[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/applyconvolution_mul_arbiter_mul.sv
// Pipelined unsigned multiplier with clock enable. Operands are registered,
// then the product passes through NUM_STAGE-2 product registers.
//   clk  : clock, rising edge
//   ce   : advances every stage when 1, holds all stages when 0
//   din0 : operand A
//   din1 : operand B
//   dout : full-width product, NUM_STAGE-1 enabled cycles after the operands
// Data registers carry no reset; their contents are qualified externally.
module applyConvolution_mul_32ns_32ns_64_3_1 #(
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic [din0_WIDTH-1:0] r_a_p1;
  logic [din1_WIDTH-1:0] r_b_p1;
  logic [dout_WIDTH-1:0] w_prod;
  logic [dout_WIDTH-1:0] r_prod_p2 [NUM_STAGE-2];

  assign w_prod = dout_WIDTH'(r_a_p1) * dout_WIDTH'(r_b_p1);

  // Stage 1: operand registers
  always_ff @(posedge clk) begin
    if (ce) begin
      r_a_p1 <= din0;
      r_b_p1 <= din1;
    end
  end

  // Stage 2+: product registers
  always_ff @(posedge clk) begin
    if (ce) begin
      r_prod_p2[0] <= w_prod;
      for (int i = 1; i < NUM_STAGE - 2; i++) r_prod_p2[i] <= r_prod_p2[i-1];
    end
  end

  assign dout = r_prod_p2[NUM_STAGE-3];

endmodule

// File: rtl/applyconvolution_mul_arbiter_rr.sv
// Round-robin grant for the shared multiplier.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   i_req_valid : per-requester operand valid
//   i_ce        : pipe advance enable; grants are only offered when it is 1
//   o_grant     : winning requester index (0 when none valid)
//   o_found     : a requester is valid this cycle
//   o_req_ready : one-hot accept for the winner, all zero otherwise
module applyConvolution_rr_arbiter
  import applyConvolution_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic             i_ce,
  output logic [ID_W-1:0]  o_grant,
  output logic             o_found,
  output logic [N_REQ-1:0] o_req_ready
);

  logic [ID_W-1:0]      r_rr_ptr;
  logic [N_REQ_MAX-1:0] w_req_ext;
  rr_pick_t             w_pick;

  always_comb begin
    w_req_ext            = '0;
    w_req_ext[N_REQ-1:0] = i_req_valid;
    w_pick               = rr_pick(w_req_ext, 3'(r_rr_ptr), N_REQ);
  end

  assign o_found = w_pick.found;
  assign o_grant = ID_W'(w_pick.idx);

  // No accepts are offered while reset is held, so nothing is lost into a
  // pipe that is being cleared.
  always_comb begin
    o_req_ready = '0;
    if (w_pick.found && rst_n) o_req_ready[o_grant] = i_ce;
  end

  // Pointer starts at the last index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_rr_ptr <= ID_W'(N_REQ - 1);
    else if (w_pick.found && i_ce)  r_rr_ptr <= o_grant;
  end

endmodule

// File: rtl/applyconvolution_mul_arbiter.sv
// Shares one pipelined 32x32->64 unsigned multiplier among N_REQ requesters.
// Round-robin grant, requester tag carried alongside the multiplier pipe,
// and the whole pipe stalls when a result is waiting on res_ready.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   req_valid : per-requester operand valid
//   req_ready : per-requester accept, at most one bit high
//   req_a     : packed operand A, requester i at [i*DIN_W +: DIN_W]
//   req_b     : packed operand B, same packing
//   res_valid : product valid
//   res_ready : consumer accepts product
//   res_data  : product a*b (0 when res_valid=0)
//   res_id    : index of the requester that issued the operands
//   busy      : any operation in flight
//   occupancy : number of operations in flight (0..2)
module applyconvolution_mul_arbiter
  import applyConvolution_mul_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*DIN_W-1:0] req_a,
  input  logic [N_REQ*DIN_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DOUT_W-1:0]      res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy,
  output logic [1:0]             occupancy
);

  logic              w_ce;
  logic              w_found;
  logic              w_accept;
  logic [ID_W-1:0]   w_grant;
  logic [DIN_W-1:0]  w_din0;
  logic [DIN_W-1:0]  w_din1;
  logic [DOUT_W-1:0] w_dout;
  logic              r_vld_p1;
  logic              r_vld_p2;
  logic [ID_W-1:0]   r_tag_p1;
  logic [ID_W-1:0]   r_tag_p2;

  // Only a waiting, unconsumed result blocks the pipe.
  assign w_ce     = ~(r_vld_p2 & ~res_ready);
  assign w_accept = w_found & w_ce;

  applyConvolution_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (reset),
    .i_req_valid (req_valid),
    .i_ce        (w_ce),
    .o_grant     (w_grant),
    .o_found     (w_found),
    .o_req_ready (req_ready)
  );

  assign w_din0 = req_a[int'(w_grant)*DIN_W +: DIN_W];
  assign w_din1 = req_b[int'(w_grant)*DIN_W +: DIN_W];

  applyConvolution_mul_32ns_32ns_64_3_1 #(
    .NUM_STAGE  (MUL_LAT + 1),
    .din0_WIDTH (DIN_W),
    .din1_WIDTH (DIN_W),
    .dout_WIDTH (DOUT_W)
  ) u_mul (
    .clk  (clk),
    .ce   (w_ce),
    .din0 (w_din0),
    .din1 (w_din1),
    .dout (w_dout)
  );

  // Stage 1 mirrors the operand registers, stage 2 the product register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1 <= 1'b0;
      r_tag_p1 <= '0;
      r_vld_p2 <= 1'b0;
      r_tag_p2 <= '0;
    end else if (w_ce) begin
      r_vld_p1 <= w_accept;
      r_tag_p1 <= w_grant;
      r_vld_p2 <= r_vld_p1;
      r_tag_p2 <= r_tag_p1;
    end
  end

  // Output: product register qualified by stage-2 valid
  assign res_valid = r_vld_p2;
  assign res_id    = r_tag_p2;
  assign res_data  = r_vld_p2 ? w_dout : '0;
  assign busy      = r_vld_p1 | r_vld_p2;
  assign occupancy = {1'b0, r_vld_p1} + {1'b0, r_vld_p2};

endmodule

// File: tb/tb_applyconvolution_mul_arbiter.sv
module tb_applyconvolution_mul_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;
  logic [1:0]    res_id;
  logic          busy;
  logic [1:0]    occupancy;

  int errors = 0;
  int checks = 0;

  applyconvolution_mul_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
  endtask

  task automatic test_reset();
    reset = 1'b0; res_ready = 1'b1; req_a = '0; req_b = '0;
    req_valid = 4'b0001;
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (res_data !== 64'd0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    req_valid = '0;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_single();
    set_op(0, 32'd3, 32'd5);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_p1: got %b want 1", busy); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occ_p1: got %0d want 1", occupancy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 64'd15) begin errors++; $display("FAIL single_data: got %0d want 15", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", res_id); end
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid: got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_after_busy: got %b want 0", busy); end
    checks++; if (res_data !== 64'd0) begin errors++; $display("FAIL single_after_data: got %h want 0", res_data); end
  endtask

  task automatic test_max_operands();
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL max_ready: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL max_data: got %h want fffffffe00000001", res_data); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL max_id: got %0d want 2", res_id); end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic [1:0]  exp_id;
    logic [63:0] exp_data;
    reset = 1'b0; #1; reset = 1'b1; #1;
    for (int i = 0; i < N; i++) set_op(i, 32'(10 + i), 32'(100 + i));
    req_valid = 4'b1111;
    for (int j = 0; j < 10; j++) begin
      if (j == 8) req_valid = '0;
      #1;
      if (j < 8) begin
        exp_rdy = 4'(1 << (j % 4));
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", j, req_ready, exp_rdy); end
      end
      if (j >= 2) begin
        exp_id   = 2'((j - 2) % 4);
        exp_data = 64'((10 + exp_id) * (100 + exp_id));
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b want 1", j, res_valid); end
        checks++; if (res_id !== exp_id) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", j, res_id, exp_id); end
        checks++; if (res_data !== exp_data) begin errors++; $display("FAIL rr_data[%0d]: got %0d want %0d", j, res_data, exp_data); end
      end
      step();
    end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_drain_valid: got %b want 0", res_valid); end
  endtask

  task automatic test_back_pressure();
    set_op(1, 32'd7, 32'd9);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready_op1: got %b want 0010", req_ready); end
    step();
    set_op(2, 32'd11, 32'd13);
    req_valid = 4'b0100;
    res_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_ready_op2: got %b want 0100", req_ready); end
    step();
    set_op(0, 32'd2, 32'd3);
    req_valid = 4'b0001;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d]: got %b want 1", s, res_valid); end
      checks++; if (res_data !== 64'd63) begin errors++; $display("FAIL bp_stall_data[%0d]: got %0d want 63", s, res_data); end
      checks++; if (res_id !== 2'd1) begin errors++; $display("FAIL bp_stall_id[%0d]: got %0d want 1", s, res_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", s, req_ready); end
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_stall_occ[%0d]: got %0d want 2", s, occupancy); end
      step();
    end
    res_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b want 0001", req_ready); end
    checks++; if (res_data !== 64'd63) begin errors++; $display("FAIL bp_release_data: got %0d want 63", res_data); end
    step();
    req_valid = '0;
    #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 64'd143) begin errors++; $display("FAIL bp_second_data: got %0d want 143", res_data); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL bp_second_id: got %0d want 2", res_id); end
    step();
    checks++; if (res_data !== 64'd6) begin errors++; $display("FAIL bp_third_data: got %0d want 6", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL bp_third_id: got %0d want 0", res_id); end
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b want 0", res_valid); end
  endtask

  task automatic test_bubbles();
    logic exp_v;
    for (int j = 0; j < 10; j++) begin
      if ((j % 2 == 0) && j <= 6) begin
        set_op(1, 32'(j + 1), 32'd4);
        req_valid = 4'b0010;
      end else begin
        req_valid = '0;
      end
      #1;
      exp_v = (j >= 2) && ((j - 2) % 2 == 0) && (j - 2 <= 6);
      checks++; if (res_valid !== exp_v) begin errors++; $display("FAIL bub_valid[%0d]: got %b want %b", j, res_valid, exp_v); end
      if (exp_v) begin
        checks++; if (res_data !== 64'((j - 1) * 4)) begin errors++; $display("FAIL bub_data[%0d]: got %0d want %0d", j, res_data, (j - 1) * 4); end
        checks++; if (res_id !== 2'd1) begin errors++; $display("FAIL bub_id[%0d]: got %0d want 1", j, res_id); end
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    set_op(2, 32'd2, 32'd2);
    req_valid = 4'b0100;
    step();
    set_op(3, 32'd3, 32'd3);
    req_valid = 4'b1000;
    step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL mid_occ_before: got %0d want 2", occupancy); end
    set_op(0, 32'd5, 32'd6);
    set_op(3, 32'h0001_0000, 32'h0001_0000);
    req_valid = 4'b1001;
    reset = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", res_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL mid_reset_occ: got %0d want 0", occupancy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready: got %b want 0000", req_ready); end
    step();
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_no_pulse: got %b want 0", res_valid); end
    step();
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_second_grant: got %b want 1000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_no_pulse2: got %b want 0", res_valid); end
    step();
    req_valid = '0;
    #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_res0_valid: got %b want 1", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL mid_res0_id: got %0d want 0", res_id); end
    checks++; if (res_data !== 64'd30) begin errors++; $display("FAIL mid_res0_data: got %0d want 30", res_data); end
    step();
    checks++; if (res_id !== 2'd3) begin errors++; $display("FAIL mid_res3_id: got %0d want 3", res_id); end
    checks++; if (res_data !== 64'h1_0000_0000) begin errors++; $display("FAIL mid_res3_data: got %h want 100000000", res_data); end
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_drain_valid: got %b want 0", res_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max_operands();
    test_round_robin();
    test_back_pressure();
    test_bubbles();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
